// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the arbiter: one request channel toward the unified
// memory macro and the read-response channel coming back.
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
) ();
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  // Arbiter side issues requests and consumes responses.
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  // Memory macro side.
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch,
// data load/store and the debug writer. Fixed priority dbg > dm > if, with a
// starvation counter that lets a waiting fetch beat dm, one transaction in
// flight, and a per-transaction timeout that aborts a stuck access.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | no transaction; arbitrate among pending requests
// ST_ISSUE     | mem_req held with stable fields until mem_ready
// ST_WAIT_RESP | read accepted; waiting for mem_rvalid
module mem_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_if_req,
  input  logic [XLEN-1:0]    i_if_addr,
  output logic               o_if_gnt,
  output logic               o_if_rvalid,
  output logic [XLEN-1:0]    o_if_rdata,
  input  logic               i_dm_req,
  input  logic               i_dm_we,
  input  logic [XLEN-1:0]    i_dm_addr,
  input  logic [XLEN-1:0]    i_dm_wdata,
  input  logic [3:0]         i_dm_wstrb,
  output logic               o_dm_gnt,
  output logic               o_dm_rvalid,
  output logic [XLEN-1:0]    o_dm_rdata,
  input  logic               i_dbg_wr_en,
  input  logic [XLEN-1:0]    i_dbg_addr,
  input  logic [XLEN-1:0]    i_dbg_instr,
  output logic               o_dbg_gnt,
  output logic               o_bus_err,
  output logic [1:0]         o_bus_err_src,
  mem_port_arbiter_if.master mem
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  // Down-counter reload: terminal count 0 is reached after TIMEOUT_CYCLES
  // cycles spent in ISSUE/WAIT_RESP.
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SRC_IF  = 2'd0;
  localparam logic [1:0] SRC_DM  = 2'd1;
  localparam logic [1:0] SRC_DBG = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_starve_cnt;
  logic [TW-1:0]   r_timer;
  logic [1:0]      r_owner;
  logic            r_is_read;

  logic            r_if_gnt;
  logic            r_if_rvalid;
  logic [XLEN-1:0] r_if_rdata;
  logic            r_dm_gnt;
  logic            r_dm_rvalid;
  logic [XLEN-1:0] r_dm_rdata;
  logic            r_dbg_gnt;
  logic            r_bus_err;
  logic [1:0]      r_bus_err_src;

  logic            r_mem_req;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic [3:0]      r_mem_wstrb;

  logic w_starved;
  logic w_win_dbg;
  logic w_win_if;
  logic w_win_dm;
  logic w_busy;
  logic w_issue_done;
  logic w_resp_done;
  logic w_timeout;

  // Arbitration: dbg always first; a starved fetch beats dm; dm beats fetch otherwise.
  assign w_starved = (r_starve_cnt == STARVE_MAX);
  assign w_win_dbg = i_dbg_wr_en;
  assign w_win_if  = !i_dbg_wr_en && i_if_req && (w_starved || !i_dm_req);
  assign w_win_dm  = !i_dbg_wr_en && !w_win_if && i_dm_req;

  // Completion beats timeout when both land on the terminal cycle.
  assign w_busy       = (r_state == ST_ISSUE) || (r_state == ST_WAIT_RESP);
  assign w_issue_done = (r_state == ST_ISSUE) && mem.mem_ready;
  assign w_resp_done  = (r_state == ST_WAIT_RESP) && mem.mem_rvalid;
  assign w_timeout    = w_busy && !w_issue_done && !w_resp_done && (r_timer == '0);

  // Sequencer: arbitration, memory handshake, response routing and timeout abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_starve_cnt  <= '0;
      r_timer       <= '0;
      r_owner       <= SRC_IF;
      r_is_read     <= 1'b0;
      r_if_gnt      <= 1'b0;
      r_if_rvalid   <= 1'b0;
      r_if_rdata    <= '0;
      r_dm_gnt      <= 1'b0;
      r_dm_rvalid   <= 1'b0;
      r_dm_rdata    <= '0;
      r_dbg_gnt     <= 1'b0;
      r_bus_err     <= 1'b0;
      r_bus_err_src <= 2'd0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_wstrb   <= 4'h0;
    end else begin
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_dbg_gnt   <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_bus_err   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_win_dbg) begin
            r_dbg_gnt   <= 1'b1;
            r_owner     <= SRC_DBG;
            r_is_read   <= 1'b0;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= i_dbg_addr;
            r_mem_wdata <= i_dbg_instr;
            r_mem_wstrb <= 4'hF;
          end else if (w_win_if) begin
            r_if_gnt    <= 1'b1;
            r_owner     <= SRC_IF;
            r_is_read   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= i_if_addr;
            r_mem_wdata <= '0;
            r_mem_wstrb <= 4'h0;
          end else if (w_win_dm) begin
            r_dm_gnt    <= 1'b1;
            r_owner     <= SRC_DM;
            r_is_read   <= !i_dm_we;
            r_mem_we    <= i_dm_we;
            r_mem_addr  <= i_dm_addr;
            r_mem_wdata <= i_dm_wdata;
            r_mem_wstrb <= i_dm_wstrb;
          end

          if (w_win_dbg || w_win_if || w_win_dm) begin
            r_mem_req <= 1'b1;
            r_timer   <= TIMER_LOAD;
            r_state   <= ST_ISSUE;
          end

          // A fetch that is pending but loses the round ages toward priority.
          if (w_win_if) begin
            r_starve_cnt <= '0;
          end else if (i_if_req && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
          end
        end

        ST_ISSUE: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end
          // Any mem_rvalid seen here is stale and deliberately dropped.
          if (w_issue_done) begin
            r_mem_req <= 1'b0;
            r_state   <= r_is_read ? ST_WAIT_RESP : ST_IDLE;
          end
        end

        ST_WAIT_RESP: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end
          if (w_resp_done) begin
            if (r_owner == SRC_IF) begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= mem.mem_rdata;
            end else begin
              r_dm_rvalid <= 1'b1;
              r_dm_rdata  <= mem.mem_rdata;
            end
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase

      // Abort: release the memory, flag the owner, and close out a read with zero data.
      if (w_timeout) begin
        r_mem_req     <= 1'b0;
        r_state       <= ST_IDLE;
        r_bus_err     <= 1'b1;
        r_bus_err_src <= r_owner;
        if (r_is_read) begin
          if (r_owner == SRC_IF) begin
            r_if_rvalid <= 1'b1;
            r_if_rdata  <= '0;
          end else begin
            r_dm_rvalid <= 1'b1;
            r_dm_rdata  <= '0;
          end
        end
      end
    end
  end

  assign o_if_gnt      = r_if_gnt;
  assign o_if_rvalid   = r_if_rvalid;
  assign o_if_rdata    = r_if_rdata;
  assign o_dm_gnt      = r_dm_gnt;
  assign o_dm_rvalid   = r_dm_rvalid;
  assign o_dm_rdata    = r_dm_rdata;
  assign o_dbg_gnt     = r_dbg_gnt;
  assign o_bus_err     = r_bus_err;
  assign o_bus_err_src = r_bus_err_src;

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign mem.mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a table of single transactions with a scripted
// memory, then hand-written sequences for contention, starvation, timeout and
// reset during a read.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dbg_wr_en;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_instr;
  logic        dbg_gnt;
  logic        bus_err;
  logic [1:0]  bus_err_src;

  mem_port_arbiter_if #(.XLEN(32)) mem_bus ();

  // Memory inputs come from either the automatic responder or the script.
  logic        auto_mem;
  logic        a_ready, a_rvalid;
  logic [31:0] a_rdata;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;
  assign mem_bus.mem_ready  = auto_mem ? a_ready  : m_ready;
  assign mem_bus.mem_rvalid = auto_mem ? a_rvalid : m_rvalid;
  assign mem_bus.mem_rdata  = auto_mem ? a_rdata  : m_rdata;

  mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_if_req      (if_req),
    .i_if_addr     (if_addr),
    .o_if_gnt      (if_gnt),
    .o_if_rvalid   (if_rvalid),
    .o_if_rdata    (if_rdata),
    .i_dm_req      (dm_req),
    .i_dm_we       (dm_we),
    .i_dm_addr     (dm_addr),
    .i_dm_wdata    (dm_wdata),
    .i_dm_wstrb    (dm_wstrb),
    .o_dm_gnt      (dm_gnt),
    .o_dm_rvalid   (dm_rvalid),
    .o_dm_rdata    (dm_rdata),
    .i_dbg_wr_en   (dbg_wr_en),
    .i_dbg_addr    (dbg_addr),
    .i_dbg_instr   (dbg_instr),
    .o_dbg_gnt     (dbg_gnt),
    .o_bus_err     (bus_err),
    .o_bus_err_src (bus_err_src),
    .mem           (mem_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Responder: ready in the first ISSUE cycle, read data one cycle later = addr + 0x1000_0000.
  logic        pend_rd;
  logic [31:0] pend_data;
  initial begin
    a_ready = 1'b0; a_rvalid = 1'b0; a_rdata = 32'h0;
    pend_rd = 1'b0; pend_data = 32'h0;
    forever begin
      @(negedge clk);
      if (auto_mem) begin
        a_rvalid = pend_rd;
        if (pend_rd) a_rdata = pend_data;
        pend_rd = 1'b0;
        a_ready = mem_bus.mem_req;
        if (mem_bus.mem_req && !mem_bus.mem_we) begin
          pend_rd   = 1'b1;
          pend_data = mem_bus.mem_addr + 32'h1000_0000;
        end
      end
    end
  end

  typedef struct {
    logic [1:0]  src;       // 0=if 1=dm 2=dbg
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] mrdata;    // data the memory returns for a read
    int          dly;       // ISSUE cycle on which mem_ready is given (1 = first)
    logic [2:0]  exp_gnt;   // {dbg,dm,if}
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_rv;    // {dm_rvalid,if_rvalid}
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic clear_reqs();
    if_req = 1'b0; dm_req = 1'b0; dbg_wr_en = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int  waitc;
    bit  got;
    @(negedge clk);
    case (v.src)
      2'd0:    begin if_req = 1'b1; if_addr = v.addr; end
      2'd1:    begin dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_wstrb = v.strb; end
      default: begin dbg_wr_en = 1'b1; dbg_addr = v.addr; dbg_instr = v.wdata; end
    endcase
    got = 1'b0;
    waitc = 0;
    while (waitc < 8 && !got) begin
      @(negedge clk);
      waitc++;
      if (if_gnt || dm_gnt || dbg_gnt) got = 1'b1;
    end
    chk("gnt_seen", 32'(got), 32'd1);
    clear_reqs();
    if (!got) return;
    chk("gnt_latency", 32'(waitc), 32'd1);
    chk("gnt_which", {29'd0, dbg_gnt, dm_gnt, if_gnt}, {29'd0, v.exp_gnt});
    for (int k = 1; k <= v.dly; k++) begin
      chk("mem_req_issue", 32'(mem_bus.mem_req), 32'd1);
      chk("mem_addr", mem_bus.mem_addr, v.addr);
      chk("mem_we", 32'(mem_bus.mem_we), 32'(v.exp_we));
      if (v.exp_we) begin
        chk("mem_wdata", mem_bus.mem_wdata, v.exp_wdata);
        chk("mem_wstrb", 32'(mem_bus.mem_wstrb), 32'(v.exp_strb));
      end
      chk("rvalid_in_issue", {30'd0, dm_rvalid, if_rvalid}, 32'd0);
      m_ready = (k == v.dly);
      @(negedge clk);
    end
    m_ready = 1'b0;
    chk("mem_req_drop", 32'(mem_bus.mem_req), 32'd0);
    chk("mem_addr_hold", mem_bus.mem_addr, v.addr);
    if (v.exp_rv != 2'b00) begin
      m_rvalid = 1'b1;
      m_rdata  = v.mrdata;
    end
    @(negedge clk);
    m_rvalid = 1'b0;
    chk("owner_rvalid", {30'd0, dm_rvalid, if_rvalid}, {30'd0, v.exp_rv});
    if (v.exp_rv == 2'b01) chk("if_rdata", if_rdata, v.exp_rdata);
    if (v.exp_rv == 2'b10) chk("dm_rdata", dm_rdata, v.exp_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int ng, nreq, n_ifrv, n_dmrv, cyc;
  int order[10];
  int exp_b[10];
  bit got_err;

  initial begin
    rst = 1'b1; auto_mem = 1'b0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    clear_reqs();
    if_addr = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_wstrb = 0; dbg_addr = 0; dbg_instr = 0;

    vecs[0] = '{src:2'd0, we:1'b0, addr:32'h0000_0010, wdata:32'h0, strb:4'h0, mrdata:32'hDEAD_BEEF, dly:1,
                exp_gnt:3'b001, exp_we:1'b0, exp_strb:4'h0, exp_wdata:32'h0, exp_rv:2'b01, exp_rdata:32'hDEAD_BEEF};
    vecs[1] = '{src:2'd1, we:1'b0, addr:32'h0000_0200, wdata:32'h0, strb:4'h0, mrdata:32'h1234_5678, dly:2,
                exp_gnt:3'b010, exp_we:1'b0, exp_strb:4'h0, exp_wdata:32'h0, exp_rv:2'b10, exp_rdata:32'h1234_5678};
    vecs[2] = '{src:2'd1, we:1'b1, addr:32'h0000_0300, wdata:32'hA5A5_A5A5, strb:4'b0011, mrdata:32'h0, dly:3,
                exp_gnt:3'b010, exp_we:1'b1, exp_strb:4'b0011, exp_wdata:32'hA5A5_A5A5, exp_rv:2'b00, exp_rdata:32'h0};
    vecs[3] = '{src:2'd2, we:1'b1, addr:32'h0000_0400, wdata:32'h0010_0073, strb:4'h0, mrdata:32'h0, dly:1,
                exp_gnt:3'b100, exp_we:1'b1, exp_strb:4'hF, exp_wdata:32'h0010_0073, exp_rv:2'b00, exp_rdata:32'h0};
    vecs[4] = '{src:2'd0, we:1'b0, addr:32'hFFFF_FFFC, wdata:32'h0, strb:4'h0, mrdata:32'h0000_0013, dly:4,
                exp_gnt:3'b001, exp_we:1'b0, exp_strb:4'h0, exp_wdata:32'h0, exp_rv:2'b01, exp_rdata:32'h0000_0013};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_gnts", {29'd0, dbg_gnt, dm_gnt, if_gnt}, 32'd0);
    chk("rst_rvalids", {30'd0, dm_rvalid, if_rvalid}, 32'd0);
    chk("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_bus_err", {29'd0, bus_err, bus_err_src}, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Three simultaneous requesters, each dropping its request on its own grant.
    auto_mem = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h90;
    dbg_wr_en = 1'b1; dbg_addr = 32'hA0; dbg_instr = 32'h1111_2222;
    ng = 0; nreq = 0; n_ifrv = 0; n_dmrv = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_bus.mem_req) nreq++;
      if (if_rvalid) n_ifrv++;
      if (dm_rvalid) n_dmrv++;
      if (dbg_gnt) begin if (ng < 10) order[ng] = 2; ng++; dbg_wr_en = 1'b0; end
      if (dm_gnt)  begin if (ng < 10) order[ng] = 1; ng++; dm_req = 1'b0; end
      if (if_gnt)  begin if (ng < 10) order[ng] = 0; ng++; if_req = 1'b0; end
    end
    chk("all3_ngnt", 32'(ng), 32'd3);
    chk("all3_first_dbg", 32'(order[0]), 32'd2);
    chk("all3_second_dm", 32'(order[1]), 32'd1);
    chk("all3_third_if", 32'(order[2]), 32'd0);
    chk("all3_mem_req_cycles", 32'(nreq), 32'd3);
    chk("all3_if_rvalid_cnt", 32'(n_ifrv), 32'd1);
    chk("all3_dm_rvalid_cnt", 32'(n_dmrv), 32'd1);
    chk("all3_if_rdata", if_rdata, 32'h1000_0080);
    chk("all3_dm_rdata", dm_rdata, 32'h1000_0090);

    // Starvation: dm and fetch both requesting continuously.
    exp_b = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'hC0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hD0;
    ng = 0;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      @(negedge clk);
      if (dm_gnt) begin order[ng] = 1; ng++; end
      else if (if_gnt) begin order[ng] = 0; ng++; end
    end
    clear_reqs();
    chk("starve_ngnt", 32'(ng), 32'd10);
    for (int i = 0; i < 10; i++) chk($sformatf("starve_order[%0d]", i), 32'(order[i]), 32'(exp_b[i]));
    repeat (10) @(negedge clk);
    auto_mem = 1'b0;

    // Load that never gets a response: timeout after 64 busy cycles.
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    @(negedge clk);
    chk("to_gnt", 32'(dm_gnt), 32'd1);
    clear_reqs();
    nreq = 0; cyc = 0; got_err = 1'b0;
    if (mem_bus.mem_req) nreq++;
    while (cyc < 100 && !got_err) begin
      @(negedge clk);
      cyc++;
      if (bus_err) got_err = 1'b1;
      else if (mem_bus.mem_req) nreq++;
    end
    chk("to_seen", 32'(got_err), 32'd1);
    chk("to_cycles", 32'(cyc), 32'd64);
    chk("to_mem_req_cycles", 32'(nreq), 32'd64);
    chk("to_src", 32'(bus_err_src), 32'd1);
    chk("to_dm_rvalid", 32'(dm_rvalid), 32'd1);
    chk("to_dm_rdata", dm_rdata, 32'd0);
    chk("to_mem_req_low", 32'(mem_bus.mem_req), 32'd0);
    m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    m_rvalid = 1'b0;
    chk("late_rvalid_ignored", {30'd0, dm_rvalid, if_rvalid}, 32'd0);
    chk("late_dm_rdata", dm_rdata, 32'd0);
    chk("bus_err_pulse", 32'(bus_err), 32'd0);
    run_txn(vecs[0]);

    // Reset while a fetch waits for its response.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk("rw_gnt", 32'(if_gnt), 32'd1);
    clear_reqs();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rw_gnts", {29'd0, dbg_gnt, dm_gnt, if_gnt}, 32'd0);
    chk("rw_rvalids", {30'd0, dm_rvalid, if_rvalid}, 32'd0);
    chk("rw_if_rdata", if_rdata, 32'd0);
    chk("rw_dm_rdata", dm_rdata, 32'd0);
    chk("rw_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rw_mem_addr", mem_bus.mem_addr, 32'd0);
    chk("rw_mem_fields", {27'd0, mem_bus.mem_we, mem_bus.mem_wstrb} | mem_bus.mem_wdata, 32'd0);
    chk("rw_bus_err", {29'd0, bus_err, bus_err_src}, 32'd0);
    m_rvalid = 1'b1; m_rdata = 32'h7777_7777;
    @(negedge clk);
    m_rvalid = 1'b0;
    chk("rw_late_rvalid", {30'd0, dm_rvalid, if_rvalid}, 32'd0);
    chk("rw_late_rdata", if_rdata, 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
